// File: rtl/montgomery_operand_mul.sv
// Operand stage of a Montgomery multiplier: shift-and-add product of two q_bl-bit
// operands, issued to the reduction stage with a minimum spacing between start pulses.
module montgomery_operand_mul #(
  parameter int DATA_LENGTH = 64,
  parameter int ISSUE_GAP   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [DATA_LENGTH-1:0] a_i,
  input  logic [DATA_LENGTH-1:0] b_i,
  input  logic [DATA_LENGTH-1:0] q_i,
  input  logic [DATA_LENGTH-1:0] q_bl_i,
  input  logic [DATA_LENGTH-1:0] qinv_i,
  output logic                   start_o,
  output logic [DATA_LENGTH-1:0] x_o,
  output logic [DATA_LENGTH-1:0] q_o,
  output logic [DATA_LENGTH-1:0] q_bl_o,
  output logic [DATA_LENGTH-1:0] qinv_o,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int CNT_W = $clog2(DATA_LENGTH) + 1;
  localparam int GAP_W = $clog2(ISSUE_GAP) + 1;
  localparam logic [DATA_LENGTH-1:0] HALF_BL  = DATA_LENGTH'(DATA_LENGTH / 2);
  localparam logic [GAP_W-1:0]       GAP_LOAD = GAP_W'(ISSUE_GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_WAIT, S_ISSUE} state_t;

  state_t                 r_state;
  logic [DATA_LENGTH-1:0] r_acc;
  logic [DATA_LENGTH-1:0] r_a_sh;
  logic [DATA_LENGTH-1:0] r_b_sh;
  logic [DATA_LENGTH-1:0] r_q;
  logic [DATA_LENGTH-1:0] r_qbl;
  logic [DATA_LENGTH-1:0] r_qinv;
  logic [CNT_W-1:0]       r_cnt;
  logic [GAP_W-1:0]       r_gap;

  logic                   w_accept;
  logic                   w_bad_bl;
  logic                   w_issue;
  logic [DATA_LENGTH-1:0] w_mask;
  logic [DATA_LENGTH-1:0] w_acc_nxt;
  logic [DATA_LENGTH-1:0] w_x;

  assign in_ready_o = (r_state == S_IDLE) && !rst_i;
  assign w_accept   = in_valid_i && in_ready_o;
  assign w_bad_bl   = (q_bl_i == '0) || (q_bl_i > HALF_BL);
  assign w_mask     = ~({DATA_LENGTH{1'b1}} << q_bl_i);
  assign w_acc_nxt  = r_b_sh[0] ? (r_acc + r_a_sh) : r_acc;

  // Issue straight out of the last MUL iteration, or from WAIT, once the gap has drained.
  assign w_issue = (((r_state == S_MUL) && (r_cnt == CNT_W'(1))) || (r_state == S_WAIT))
                   && (r_gap == '0);
  assign w_x     = (r_state == S_MUL) ? w_acc_nxt : r_acc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_q     <= '0;
      r_qbl   <= '0;
      r_qinv  <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      start_o <= 1'b0;
      err_o   <= 1'b0;
      busy_o  <= 1'b0;
      x_o     <= '0;
      q_o     <= '0;
      q_bl_o  <= '0;
      qinv_o  <= '0;
    end else begin
      start_o <= 1'b0;
      err_o   <= 1'b0;
      if (r_gap != '0) r_gap <= r_gap - GAP_W'(1);

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a_sh <= a_i & w_mask;
            r_b_sh <= b_i & w_mask;
            r_acc  <= '0;
            r_q    <= q_i;
            r_qbl  <= q_bl_i;
            r_qinv <= qinv_i;
            r_cnt  <= q_bl_i[CNT_W-1:0];
            if (w_bad_bl) begin
              err_o <= 1'b1;
            end else begin
              r_state <= S_MUL;
              busy_o  <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_acc  <= w_acc_nxt;
          r_a_sh <= r_a_sh << 1;
          r_b_sh <= r_b_sh >> 1;
          r_cnt  <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= S_WAIT;
        end
        S_WAIT: begin
        end
        S_ISSUE: begin
          r_state <= S_IDLE;
          busy_o  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase

      // Outputs hold from one start pulse to the next; the gap window opens on the pulse.
      if (w_issue) begin
        r_state <= S_ISSUE;
        start_o <= 1'b1;
        x_o     <= w_x;
        q_o     <= r_q;
        q_bl_o  <= r_qbl;
        qinv_o  <= r_qinv;
        r_gap   <= GAP_LOAD;
      end
    end
  end

endmodule

// File: tb/tb_montgomery_operand_mul.sv
// Scoreboard bench for montgomery_operand_mul: driver pushes expected results,
// an independent monitor pops them on every start/err pulse.
module tb_montgomery_operand_mul;
  localparam int DL  = 64;
  localparam int GAP = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [DL-1:0] a_i = '0, b_i = '0, q_i = '0, q_bl_i = '0, qinv_i = '0;
  logic          start_o, busy_o, err_o;
  logic [DL-1:0] x_o, q_o, q_bl_o, qinv_o;

  montgomery_operand_mul #(.DATA_LENGTH(DL), .ISSUE_GAP(GAP)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .a_i(a_i), .b_i(b_i), .q_i(q_i), .q_bl_i(q_bl_i), .qinv_i(qinv_i),
    .start_o(start_o), .x_o(x_o), .q_o(q_o), .q_bl_o(q_bl_o), .qinv_o(qinv_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [63:0] x;
    logic [63:0] q;
    logic [63:0] qbl;
    logic [63:0] qinv;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          starts[$];
  int          last_start = -1000;
  logic [63:0] hold_x = '0;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: product of the operands truncated to their low q_bl bits.
  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] qbl);
    logic [63:0] m;
    m = (qbl >= 64) ? '1 : ((64'd1 << qbl) - 64'd1);
    return (a & m) * (b & m);
  endfunction

  // Monitor: every start/err pulse must match the oldest outstanding operand set.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (start_o || err_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {62'd0, start_o, err_o}, 64'd0);
        end else begin
          exp_t e;
          int   ec;
          e = sb.pop_front();
          if (start_o) begin
            chk("kind_start", {63'd0, e.is_err}, 64'd0);
            ec = e.acc + int'(e.qbl) + 1;
            if (last_start + GAP > ec) ec = last_start + GAP;
            chk("start_cycle", 64'(cyc), 64'(ec));
            chk("x_o", x_o, e.x);
            chk("q_o", q_o, e.q);
            chk("q_bl_o", q_bl_o, e.qbl);
            chk("qinv_o", qinv_o, e.qinv);
            last_start = cyc;
            hold_x     = e.x;
            starts.push_back(cyc);
          end else begin
            chk("kind_err", {63'd0, e.is_err}, 64'd1);
            chk("err_cycle", 64'(cyc), 64'(e.acc + 1));
          end
        end
      end else begin
        chk("x_hold", x_o, hold_x);
      end
    end
  end

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [63:0] q,
                      input logic [63:0] qbl, input logic [63:0] qinv);
    int   n;
    exp_t e;
    a_i = a; b_i = b; q_i = q; q_bl_i = qbl; qinv_i = qinv;
    in_valid_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!in_ready_o && n < 300);
    if (!in_ready_o) begin
      chk("accept_timeout", 64'd0, 64'd1);
    end else begin
      e.is_err = (qbl == 0) || (qbl > 64'(DL / 2));
      e.x      = ref_mul(a, b, qbl);
      e.q      = q;
      e.qbl    = qbl;
      e.qinv   = qinv;
      e.acc    = cyc;
      sb.push_back(e);
    end
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    idle(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_start"}, {63'd0, start_o}, 64'd0);
    chk({tag, "_err"}, {63'd0, err_o}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
    chk({tag, "_ready"}, {63'd0, in_ready_o}, 64'd0);
    chk({tag, "_x"}, x_o, 64'd0);
    chk({tag, "_q"}, q_o, 64'd0);
    chk({tag, "_qbl"}, q_bl_o, 64'd0);
    chk({tag, "_qinv"}, qinv_o, 64'd0);
  endtask

  initial begin
    int s;
    logic [63:0] qbl;

    // Power-on reset
    repeat (3) @(negedge clk_i);
    check_reset_outputs("rst");
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("ready_after_rst", {63'd0, in_ready_o}, 64'd1);
    idle(1);

    // Basic: busy over the MUL cycles and the issue cycle, then idle
    send(64'd13, 64'd11, 64'd17, 64'd5, 64'd7);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk_i);
      chk("basic_busy", {63'd0, busy_o}, 64'd1);
    end
    @(negedge clk_i);
    chk("basic_idle", {63'd0, busy_o}, 64'd0);
    drain();
    chk("basic_x", x_o, 64'd143);

    // Rejection of out-of-range bit lengths
    idle(GAP + 2);
    send(64'd9, 64'd9, 64'd17, 64'd0, 64'd1);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rej0_ready", {63'd0, in_ready_o}, 64'd1);
    idle(1);
    send(64'd9, 64'd9, 64'd17, 64'd33, 64'd1);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rej33_ready", {63'd0, in_ready_o}, 64'd1);
    drain();
    chk("rej_x_unchanged", x_o, 64'd143);

    // Masking of operand bits above q_bl
    idle(GAP + 2);
    send(64'hFFFF_FFE0_0000_000D, 64'd3, 64'd17, 64'd5, 64'd2);
    drain();
    chk("mask_x", x_o, 64'd39);

    // Maximum bit length
    idle(GAP + 2);
    send(64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFB, 64'd32, 64'd3);
    drain();
    chk("max_x", x_o, 64'hFFFF_FFFE_0000_0001);

    // Spacing: second set is stalled in WAIT behind the gap window
    idle(GAP + 2);
    send(64'd3, 64'd5, 64'd17, 64'd5, 64'd1);
    send(64'd7, 64'd6, 64'd19, 64'd5, 64'd1);
    repeat (7) @(negedge clk_i);
    chk("spacing_wait_busy", {63'd0, busy_o}, 64'd1);
    chk("spacing_wait_nostart", {63'd0, start_o}, 64'd0);
    drain();
    s = starts.size();
    chk("spacing_gap", 64'(starts[s-1] - starts[s-2]), 64'(GAP));

    // Reset in the middle of a multiply aborts it
    idle(GAP + 2);
    send(64'd21, 64'd29, 64'd31, 64'd5, 64'd1);
    idle(2);
    rst_i = 1'b1;
    sb.delete();
    last_start = -1000;
    hold_x     = '0;
    @(negedge clk_i);
    check_reset_outputs("midrst");
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    idle(20);
    send(64'd21, 64'd29, 64'd31, 64'd5, 64'd1);
    drain();
    chk("post_rst_x", x_o, 64'd609);

    // Randomized traffic, including rejected sets and gap stalls
    for (int t = 0; t < 40; t++) begin
      idle($urandom_range(0, 4));
      if ($urandom_range(0, 9) == 0) begin
        qbl = ($urandom_range(0, 1) == 0) ? 64'd0 : 64'($urandom_range(33, 80));
      end else begin
        qbl = 64'($urandom_range(1, 32));
      end
      send({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, qbl,
           {$urandom, $urandom});
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, %0d checks so far", n_tests);
    $fatal(1);
  end

endmodule

// File: doc/montgomery_operand_mul.md
MONTGOMERY_OPERAND_MUL -- requirements
Module: montgomery_operand_mul

Interface
REQ-001 The block SHALL have parameter DATA_LENGTH, default 64, giving the datapath width.
REQ-002 The block SHALL have parameter ISSUE_GAP, default 16, giving the minimum number of cycles between consecutive start_o pulses.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Port clk_i: input, 1 bit, rising-edge clock.
REQ-005 Port rst_i: input, 1 bit, asynchronous active-high reset.
REQ-006 Port in_valid_i: input, 1 bit, operand set valid.
REQ-007 Port in_ready_o: output, 1 bit, block can accept an operand set.
REQ-008 Ports a_i and b_i: input, DATA_LENGTH bits each, multiplicands already in Montgomery form.
REQ-009 Ports q_i, q_bl_i and qinv_i: input, DATA_LENGTH bits each, modulus, modulus bit length and modular inverse.
REQ-010 Port start_o: output, 1 bit, one-cycle start pulse to the reduction stage.
REQ-011 Port x_o: output, DATA_LENGTH bits, product a*b.
REQ-012 Ports q_o, q_bl_o and qinv_o: output, DATA_LENGTH bits each, captured q_i, q_bl_i and qinv_i.
REQ-013 Port busy_o: output, 1 bit, high while state is not IDLE.
REQ-014 Port err_o: output, 1 bit, one-cycle pulse marking a rejected operand set.

Function
REQ-015 The block SHALL implement states IDLE, MUL, WAIT and ISSUE.
REQ-016 in_ready_o SHALL equal (state==IDLE); an operand set is accepted in a cycle where in_valid_i and in_ready_o are both high.
REQ-017 On accept, the block SHALL register a_i and b_i masked to their low q_bl_i bits, together with q_i, q_bl_i and qinv_i, and SHALL clear the accumulator.
REQ-018 If q_bl_i is 0 or greater than DATA_LENGTH/2, the block SHALL pulse err_o in the cycle after accept, stay in IDLE and produce no start_o.
REQ-019 Otherwise the block SHALL enter MUL with iteration counter set to q_bl.
REQ-020 Each MUL cycle SHALL perform: if b_sh[0] then acc += a_sh; then a_sh <<= 1, b_sh >>= 1, counter -= 1.
REQ-021 acc SHALL be DATA_LENGTH bits wide and SHALL never overflow, because the product is less than 2^(2*q_bl).
REQ-022 When the counter reaches 0, the block SHALL go to ISSUE if the gap counter is 0, else to WAIT.
REQ-023 WAIT SHALL go to ISSUE in the cycle after the gap counter reaches 0.
REQ-024 ISSUE SHALL last exactly one cycle with start_o=1 and x_o=acc, then go to IDLE.
REQ-025 With no gap stall, if accept occurs in cycle k, start_o SHALL be high in cycle k+q_bl+1.
REQ-026 x_o, q_o, q_bl_o and qinv_o SHALL be valid in the start_o cycle and SHALL hold until the next start_o.
REQ-027 On start_o, the gap counter SHALL load ISSUE_GAP-1 and decrement each cycle to 0, so rising edges of start_o are at least ISSUE_GAP cycles apart.
REQ-028 A new accept SHALL be allowed while the gap counter is nonzero, so the multiply overlaps the gap.
REQ-029 The block SHALL NOT check that a and b are less than q; keeping x < q*2^q_bl is the caller's responsibility.

Reset
REQ-030 While rst_i is high: state=IDLE; acc, gap counter, start_o, err_o, busy_o, x_o, q_o, q_bl_o and qinv_o all 0; in_ready_o=0.
REQ-031 in_ready_o SHALL be 1 in the first cycle after rst_i deasserts.
REQ-032 Reset asserted mid-MUL or mid-WAIT SHALL abort the operation, and no start_o SHALL follow for the aborted operand set.

Verification
REQ-033 Scenario basic: q=17, q_bl=5, a=13, b=11, accept in cycle k -> start_o in cycle k+6 only, x_o=143, q_o=17, q_bl_o=5, busy_o high during cycles k+1..k+6.
REQ-034 Scenario spacing: q_bl=5, ISSUE_GAP=16, two operand sets with in_valid_i held high -> second start_o exactly 16 cycles after the first, and WAIT entered for the second set.
REQ-035 Scenario rejection: q_bl=0, then q_bl=33 -> err_o pulses once for each, no start_o, in_ready_o=1 in the cycle after each err_o.
REQ-036 Scenario masking: a=0xFFFFFFE00000000D, b=3, q_bl=5 -> x_o=39.
REQ-037 Scenario maximum width: q_bl=32, a=b=0xFFFFFFFF -> x_o=0xFFFFFFFE00000001, start_o in cycle k+33.
REQ-038 Scenario reset: rst_i pulsed in cycle k+3 of a q_bl=5 operation -> all outputs 0, no start_o afterwards, next operand set processed normally.
